// File: rtl/match_controller.sv
// Pong match sequencer: scoring, serve delay between rallies, win detection and win-text hold.
// Every output is a registered copy of FSM state. They all update together on the clock edge after the input that caused the change.
module match_controller #(
  parameter int          WIN_SCORE          = 7,
  parameter int          SERVE_DELAY_FRAMES = 60,
  parameter int          WIN_HOLD_FRAMES    = 180,
  parameter logic [2:0]  PLAYER_1_COLOR     = 3'b100,
  parameter logic [2:0]  PLAYER_2_COLOR     = 3'b001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [2:0] winner,
  output logic       game_active,
  output logic       serve_dir
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, WIN} state_t;

  localparam logic [3:0] WIN_PTS    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_DELAY_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(WIN_HOLD_FRAMES - 1);

  state_t     state;
  logic [7:0] frame_cnt;
  logic [3:0] next_p1;
  logic [3:0] next_p2;

  assign next_p1 = score_p1 + 4'd1;
  assign next_p2 = score_p2 + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      winner      <= 3'b000;
      game_active <= 1'b0;
      serve_dir   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            serve_dir <= 1'b1;
            frame_cnt <= 8'd0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          // Ticks only count once the FSM is already in SERVE; the entry edge cleared the counter.
          if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) begin
              frame_cnt   <= 8'd0;
              game_active <= 1'b1;
              state       <= PLAY;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        PLAY: begin
          if (point_p1 || point_p2) begin
            game_active <= 1'b0;
            frame_cnt   <= 8'd0;
            state       <= SERVE;
            // A double point is a replayed rally: scores and serve direction are untouched.
            if (point_p1 && !point_p2) begin
              score_p1 <= next_p1;
              if (next_p1 == WIN_PTS) begin
                winner <= PLAYER_1_COLOR;
                state  <= WIN;
              end else begin
                serve_dir <= 1'b1;
              end
            end else if (point_p2 && !point_p1) begin
              score_p2 <= next_p2;
              if (next_p2 == WIN_PTS) begin
                winner <= PLAYER_2_COLOR;
                state  <= WIN;
              end else begin
                serve_dir <= 1'b0;
              end
            end
          end
        end
        WIN: begin
          if (frame_tick) begin
            if (frame_cnt == HOLD_LAST) begin
              frame_cnt <= 8'd0;
              winner    <= 3'b000;
              state     <= IDLE;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: a default-parameter instance plus a 1/1/1 corner instance.
module tb_match_controller;

  localparam logic [2:0] P1C = 3'b100;
  localparam logic [2:0] P2C = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0, start = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0;
  logic c_frame_tick = 1'b0, c_start = 1'b0, c_point_p1 = 1'b0, c_point_p2 = 1'b0;
  logic [3:0] score_p1, score_p2, c_score_p1, c_score_p2;
  logic [2:0] winner, c_winner;
  logic game_active, serve_dir, c_game_active, c_serve_dir;

  int evaluated = 0;
  int failures  = 0;

  typedef struct {
    string      tag;
    bit         corner;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [2:0] w;
    logic       ga;
    logic       dir;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  match_controller #(
    .WIN_SCORE(7), .SERVE_DELAY_FRAMES(60), .WIN_HOLD_FRAMES(180),
    .PLAYER_1_COLOR(P1C), .PLAYER_2_COLOR(P2C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .point_p1(point_p1), .point_p2(point_p2), .score_p1(score_p1), .score_p2(score_p2),
    .winner(winner), .game_active(game_active), .serve_dir(serve_dir)
  );

  match_controller #(
    .WIN_SCORE(1), .SERVE_DELAY_FRAMES(1), .WIN_HOLD_FRAMES(1),
    .PLAYER_1_COLOR(P1C), .PLAYER_2_COLOR(P2C)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .frame_tick(c_frame_tick), .start(c_start),
    .point_p1(c_point_p1), .point_p2(c_point_p2), .score_p1(c_score_p1), .score_p2(c_score_p2),
    .winner(c_winner), .game_active(c_game_active), .serve_dir(c_serve_dir)
  );

  task automatic chk(input string tag, input string field, input logic [3:0] obs, input logic [3:0] expv);
    evaluated++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic compare();
    exp_t e;
    logic [3:0] s1, s2;
    logic [2:0] w;
    logic ga, dir;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    if (e.corner) begin
      s1 = c_score_p1; s2 = c_score_p2; w = c_winner; ga = c_game_active; dir = c_serve_dir;
    end else begin
      s1 = score_p1; s2 = score_p2; w = winner; ga = game_active; dir = serve_dir;
    end
    chk(e.tag, "score_p1", s1, e.s1);
    chk(e.tag, "score_p2", s2, e.s2);
    chk(e.tag, "winner", {1'b0, w}, {1'b0, e.w});
    chk(e.tag, "game_active", {3'b0, ga}, {3'b0, e.ga});
    chk(e.tag, "serve_dir", {3'b0, dir}, {3'b0, e.dir});
  endtask

  // Drive one cycle of inputs, record what must be visible after the edge, then check it.
  task automatic step(input bit c, input logic st, input logic ft, input logic a, input logic b,
                      input string tag, input logic [3:0] e1, input logic [3:0] e2,
                      input logic [2:0] ew, input logic ega, input logic edir);
    if (c) begin
      c_start = st; c_frame_tick = ft; c_point_p1 = a; c_point_p2 = b;
    end else begin
      start = st; frame_tick = ft; point_p1 = a; point_p2 = b;
    end
    exp_q.push_back('{tag, c, e1, e2, ew, ega, edir});
    @(posedge clk);
    #1;
    start = 0; frame_tick = 0; point_p1 = 0; point_p2 = 0;
    c_start = 0; c_frame_tick = 0; c_point_p1 = 0; c_point_p2 = 0;
    compare();
  endtask

  // Count a full serve delay; a stray point pulse mid-serve must be ignored.
  task automatic serve(input int n, input logic [3:0] e1, input logic [3:0] e2, input logic edir);
    for (int i = 0; i < n; i++)
      step(0, 0, 1, (i == n / 2), 0, "serve_tick", e1, e2, 3'b000, (i == n - 1), edir);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then released
    step(0, 0, 0, 0, 0, "reset", 0, 0, 3'b000, 0, 1);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0, "idle_point", 0, 0, 3'b000, 0, 1);

    // Start with a coincident tick that must not count
    step(0, 1, 1, 0, 0, "start_tick", 0, 0, 3'b000, 0, 1);
    serve(60, 0, 0, 1);
    step(0, 1, 0, 0, 0, "play_hold", 0, 0, 3'b000, 1, 1);

    // Scoring and serve direction
    step(0, 0, 0, 1, 0, "p1_point", 1, 0, 3'b000, 0, 1);
    serve(60, 1, 0, 1);
    step(0, 0, 0, 0, 1, "p2_point", 1, 1, 3'b000, 0, 0);
    serve(60, 1, 1, 0);
    step(0, 0, 0, 1, 1, "double_point", 1, 1, 3'b000, 0, 0);
    serve(60, 1, 1, 0);

    // Build 3/2, then reset asynchronously mid-play
    step(0, 0, 0, 1, 0, "p1_to_2", 2, 1, 3'b000, 0, 1);
    serve(60, 2, 1, 1);
    step(0, 0, 0, 1, 0, "p1_to_3", 3, 1, 3'b000, 0, 1);
    serve(60, 3, 1, 1);
    step(0, 0, 0, 0, 1, "p2_to_2", 3, 2, 3'b000, 0, 0);
    serve(60, 3, 2, 0);
    rst_n = 1'b0;
    #1;
    exp_q.push_back('{"async_reset", 1'b0, 4'd0, 4'd0, 3'b000, 1'b0, 1'b1});
    compare();
    step(0, 1, 1, 1, 0, "reset_held", 0, 0, 3'b000, 0, 1);
    rst_n = 1'b1;

    // Player 2 runs the match; the winning pulse also carries a tick that must not count
    step(0, 1, 0, 0, 0, "start2", 0, 0, 3'b000, 0, 1);
    serve(60, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      if (k < 7) begin
        step(0, 0, 0, 0, 1, "p2_run", 0, 4'(k), 3'b000, 0, 0);
        serve(60, 0, 4'(k), 0);
      end else begin
        step(0, 0, 1, 0, 1, "p2_win", 0, 7, P2C, 0, 0);
      end
    end
    for (int i = 0; i < 180; i++)
      step(0, (i % 45 == 0), 1, (i == 20), (i == 21), "win_hold", 0, 7,
           (i == 179) ? 3'b000 : P2C, 0, 0);
    step(0, 0, 0, 1, 1, "idle_after_win", 0, 7, 3'b000, 0, 0);
    step(0, 1, 0, 0, 0, "restart", 0, 0, 3'b000, 0, 1);

    // Corner instance: one-point match, one-frame serve and hold
    step(1, 1, 0, 0, 0, "c_start", 0, 0, 3'b000, 0, 1);
    step(1, 0, 1, 0, 0, "c_serve", 0, 0, 3'b000, 1, 1);
    step(1, 0, 0, 1, 0, "c_win", 1, 0, P1C, 0, 1);
    step(1, 0, 0, 0, 0, "c_win_hold", 1, 0, P1C, 0, 1);
    step(1, 0, 1, 0, 0, "c_win_exit", 1, 0, 3'b000, 0, 1);
    step(1, 1, 0, 0, 0, "c_restart", 0, 0, 3'b000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
